// File: rtl/online_mult_sequencer.sv
// Sequencer for one N-digit radix-2 signed-digit online multiplication.
// Clears the shared datapath, streams x/y digits MSD-first, drops the first
// DELTA output digits and assembles the N product digits into res_vec.
module online_mult_sequencer #(
    parameter int unsigned NO_OF_DIGITS = 4,
    parameter int unsigned RADIX_BITS   = 2,
    parameter int unsigned DELTA        = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start_valid,
    output logic                                 start_ready,
    input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   x_vec,
    input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   y_vec,
    input  logic                                 abort,
    output logic [RADIX_BITS-1:0]                mul_x,
    output logic [RADIX_BITS-1:0]                mul_y,
    output logic                                 mul_clear,
    input  logic [RADIX_BITS-1:0]                mul_z,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [NO_OF_DIGITS*RADIX_BITS-1:0]   res_vec,
    output logic                                 res_err
);

    localparam int unsigned VecW     = NO_OF_DIGITS * RADIX_BITS;
    localparam int unsigned KW       = $clog2(NO_OF_DIGITS + DELTA);
    localparam logic [KW-1:0] KLast  = KW'(NO_OF_DIGITS + DELTA - 1);
    localparam logic [KW-1:0] KDelta = KW'(DELTA);
    // Sign bit set with zero magnitude: the one encoding that is not -1/0/+1.
    localparam logic [RADIX_BITS-1:0] IllegalDigit = {1'b1, {(RADIX_BITS-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [VecW-1:0] x_q, x_d;
    logic [VecW-1:0] y_q, y_d;
    logic [VecW-1:0] res_q, res_d;
    logic            err_q, err_d;

    function automatic logic has_illegal(input logic [VecW-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NO_OF_DIGITS; i++) begin
            if (v[i*RADIX_BITS +: RADIX_BITS] == IllegalDigit) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Next-state, datapath digit drive and result assembly.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        err_d       = err_q;
        start_ready = 1'b0;
        mul_clear   = 1'b0;
        mul_x       = '0;
        mul_y       = '0;
        res_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    x_d     = x_vec;
                    y_d     = y_vec;
                    res_d   = '0;
                    err_d   = has_illegal(x_vec) | has_illegal(y_vec);
                    state_d = StClear;
                end
            end
            StClear: begin
                mul_clear = 1'b1;
                if (abort) begin
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Operands shift out MSD-first and zero-fill, so steps k>=N drive 0.
                mul_x = x_q[VecW-1 -: RADIX_BITS];
                mul_y = y_q[VecW-1 -: RADIX_BITS];
                x_d   = x_q << RADIX_BITS;
                y_d   = y_q << RADIX_BITS;
                // First captured digit ends up in the MSD position after N shifts.
                if (k_q >= KDelta) begin
                    res_d = {res_q[VecW-RADIX_BITS-1:0], mul_z};
                    if (mul_z == IllegalDigit) begin
                        err_d = 1'b1;
                    end
                end
                if (abort) begin
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end else if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, step counter, operand and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign res_vec = res_q;
    assign res_err = err_q;

endmodule

// File: tb/tb_online_mult_sequencer.sv
// Bench for online_mult_sequencer. A stub datapath returns the digits of the
// rounded product of the operands the bench issued, aligned to the DUT clear.
module tb_online_mult_sequencer;

    localparam int N  = 4;
    localparam int RB = 2;
    localparam int D  = 3;
    localparam int W  = N * RB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start_valid = 1'b0;
    logic         abort = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] x_vec = '0;
    logic [W-1:0] y_vec = '0;
    logic         start_ready;
    logic [RB-1:0] mul_x, mul_y, mul_z;
    logic         mul_clear, res_valid, res_err;
    logic [W-1:0] res_vec;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int prod;
        bit err;
        bit chk;
    } exp_t;
    exp_t exp_q[$];

    // Stub datapath state.
    logic [W-1:0] stub_next = '0;
    logic [W-1:0] stub_cur = '0;
    int           stub_inj_next = -1;
    int           stub_inj = -1;
    int           cnt = 100;

    always #5 clk = ~clk;

    online_mult_sequencer #(
        .NO_OF_DIGITS(N),
        .RADIX_BITS  (RB),
        .DELTA       (D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .x_vec      (x_vec),
        .y_vec      (y_vec),
        .abort      (abort),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_clear  (mul_clear),
        .mul_z      (mul_z),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_vec    (res_vec),
        .res_err    (res_err)
    );

    always @(posedge clk) begin
        if (mul_clear) begin
            cnt      <= 0;
            stub_cur <= stub_next;
            stub_inj <= stub_inj_next;
        end else if (cnt < 100) begin
            cnt <= cnt + 1;
        end
    end

    always_comb begin
        mul_z = '0;
        if (cnt >= D && cnt < D + N) begin
            if (cnt - D == stub_inj) mul_z = 2'b10;
            else mul_z = stub_cur[(N-1-(cnt-D))*RB +: RB];
        end
    end

    function automatic int dig_val(input logic [RB-1:0] d);
        case (d)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    // Value scaled by 2^N.
    function automatic int vec_val(input logic [W-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s = s * 2 + dig_val(v[(N-1-i)*RB +: RB]);
        return s;
    endfunction

    // p is the product scaled by 2^(2N); returns rounded N-digit signed-digit form.
    function automatic logic [W-1:0] prod_digits(input int p);
        int r, m;
        logic [W-1:0] v;
        r = (p >= 0) ? (p + 8) / 16 : -((-p + 8) / 16);
        m = (r < 0) ? -r : r;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (((m >> (N-1-i)) & 1) == 1) v[(N-1-i)*RB +: RB] = (r < 0) ? 2'b11 : 2'b01;
        end
        return v;
    endfunction

    function automatic int abs_i(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Offers one operand pair at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv, input int inj,
                         input bit exp_err, input bit chk);
        exp_t e;
        x_vec         = xv;
        y_vec         = yv;
        start_valid   = 1'b1;
        stub_next     = prod_digits(vec_val(xv) * vec_val(yv));
        stub_inj_next = inj;
        e.prod = vec_val(xv) * vec_val(yv);
        e.err  = exp_err;
        e.chk  = chk;
        exp_q.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (res_valid === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        tests_run++;
        if ({start_ready, res_valid, res_err, mul_clear} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, want 1000", {start_ready, res_valid, res_err, mul_clear});
        end
        tests_run++;
        if (res_vec !== '0) begin
            tests_failed++;
            $display("FAIL reset_res_vec: got %h, want 00", res_vec);
        end
        tests_run++;
        if ({mul_x, mul_y} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mul_xy: got %b, want 0000", {mul_x, mul_y});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        logic [2*(N+D)-1:0] xs;
        bit bad;
        xs  = '0;
        bad = 1'b0;
        issue(8'b01_00_00_00, 8'b01_00_00_00, -1, 1'b0, 1'b1);
        tests_run++;
        if ({mul_clear, start_ready, mul_x} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL basic_clear: got %b, want 1000", {mul_clear, start_ready, mul_x});
        end
        for (int i = 0; i < N + D; i++) begin
            @(negedge clk);
            xs = {xs[2*(N+D)-3:0], mul_x};
            if (mul_clear !== 1'b0 || res_valid !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (xs !== 14'b01_00_00_00_00_00_00 || bad) begin
            tests_failed++;
            $display("FAIL basic_mul_x_seq: got %b bad=%0d, want 01000000000000 bad=0", xs, bad);
        end
        @(negedge clk);
        tests_run++;
        if (res_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_latency: res_valid=%b 8 edges after accept, want 1", res_valid);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (abs_i(vec_val(res_vec) * 16 - e.prod) > 16) begin
            tests_failed++;
            $display("FAIL basic_value: got %0d/16, want %0d/256 +-16/256", vec_val(res_vec), e.prod);
        end
        tests_run++;
        if (res_err !== e.err) begin
            tests_failed++;
            $display("FAIL basic_err: got %b, want %b", res_err, e.err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests_run++;
        if ({start_ready, res_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_drain: got %b, want 10", {start_ready, res_valid});
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit ok, bad;
        logic [W-1:0] snap;
        bad = 1'b0;
        issue(8'b01_01_01_01, 8'b11_11_11_11, -1, 1'b0, 1'b1);
        wait_valid(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL hold_timeout: res_valid=%b, want 1 within 30 cycles", res_valid);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (abs_i(vec_val(res_vec) * 16 - e.prod) > 16) begin
            tests_failed++;
            $display("FAIL hold_value: got %0d/16, want %0d/256 +-16/256", vec_val(res_vec), e.prod);
        end
        snap  = res_vec;
        abort = 1'b1;  // must be ignored in DONE
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            abort = 1'b0;
            if (res_vec !== snap || res_valid !== 1'b1 || start_ready !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL hold_stable: got vec=%h valid=%b ready=%b, want vec=%h valid=1 ready=0",
                     res_vec, res_valid, start_ready, snap);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests_run++;
        if ({start_ready, res_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL hold_drain: got %b, want 10", {start_ready, res_valid});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, e2;
        bit ok;
        res_ready     = 1'b1;  // ignored until DONE
        x_vec         = 8'b00_00_00_00;
        y_vec         = 8'b01_11_00_01;
        stub_next     = prod_digits(0);
        stub_inj_next = -1;
        e.prod = 0; e.err = 1'b0; e.chk = 1'b1;
        exp_q.push_back(e);
        start_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mul_clear !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_clear: got %b, want 1", mul_clear);
        end
        @(negedge clk);
        // Stub has latched op 1; stage op 2 while start_valid stays high.
        x_vec     = 8'b01_01_00_00;
        y_vec     = 8'b01_00_11_00;
        stub_next = prod_digits(vec_val(x_vec) * vec_val(y_vec));
        e2.prod = vec_val(x_vec) * vec_val(y_vec); e2.err = 1'b0; e2.chk = 1'b1;
        exp_q.push_back(e2);
        wait_valid(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_timeout1: res_valid=%b, want 1 within 30 cycles", res_valid);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (res_vec !== '0 || res_err !== e.err) begin
            tests_failed++;
            $display("FAIL b2b_zero: got vec=%h err=%b, want vec=00 err=0", res_vec, res_err);
        end
        @(negedge clk);
        tests_run++;
        if ({start_ready, res_valid, mul_clear} !== 3'b100) begin
            tests_failed++;
            $display("FAIL b2b_handshake: got %b, want 100", {start_ready, res_valid, mul_clear});
        end
        @(negedge clk);
        start_valid = 1'b0;
        tests_run++;
        if (mul_clear !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: mul_clear=%b, want 1", mul_clear);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || abs_i(vec_val(res_vec) * 16 - e.prod) > 16) begin
            tests_failed++;
            $display("FAIL b2b_value2: got ok=%0d %0d/16, want ok=1 %0d/256 +-16/256",
                     ok, vec_val(res_vec), e.prod);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        exp_t e;
        bit ok, bad;
        bad = 1'b0;
        issue(8'b01_01_01_01, 8'b01_00_00_00, -1, 1'b0, 1'b1);
        e = exp_q.pop_back();
        for (int i = 0; i < 5; i++) @(negedge clk);  // now in RUN step k=4
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if ({start_ready, res_valid, res_err} !== 3'b100 || res_vec !== '0) begin
            tests_failed++;
            $display("FAIL abort_k4: got ctrl=%b vec=%h, want ctrl=100 vec=00",
                     {start_ready, res_valid, res_err}, res_vec);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL abort_no_valid: res_valid rose after abort, want 0");
        end
        issue(8'b01_01_01_01, 8'b01_00_00_00, -1, 1'b0, 1'b1);
        e = exp_q.pop_back();
        for (int i = 0; i < N + D; i++) @(negedge clk);  // final RUN step k=6
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if ({start_ready, res_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_last_step: got %b, want 10", {start_ready, res_valid});
        end
        issue(8'b01_00_00_00, 8'b01_00_00_00, -1, 1'b0, 1'b1);
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || abs_i(vec_val(res_vec) * 16 - e.prod) > 16 || res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_next_op: got ok=%0d %0d/16 err=%b, want ok=1 %0d/256 +-16/256 err=0",
                     ok, vec_val(res_vec), res_err, e.prod);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_err();
        exp_t e;
        bit ok;
        issue(8'b10_01_00_00, 8'b01_00_00_00, -1, 1'b1, 1'b0);
        tests_run++;
        if (res_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_operand_at_accept: got %b, want 1", res_err);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || res_err !== e.err) begin
            tests_failed++;
            $display("FAIL err_operand_done: got ok=%0d err=%b, want ok=1 err=%b", ok, res_err, e.err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        issue(8'b01_00_00_00, 8'b01_00_00_00, 1, 1'b1, 1'b0);
        tests_run++;
        if (res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_cleared_on_accept: got %b, want 0", res_err);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || res_err !== e.err) begin
            tests_failed++;
            $display("FAIL err_mul_z: got ok=%0d err=%b, want ok=1 err=%b", ok, res_err, e.err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        issue(8'b01_01_00_00, 8'b01_00_00_00, -1, 1'b0, 1'b1);
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || res_err !== e.err || abs_i(vec_val(res_vec) * 16 - e.prod) > 16) begin
            tests_failed++;
            $display("FAIL err_clean_op: got ok=%0d err=%b %0d/16, want ok=1 err=0 %0d/256 +-16/256",
                     ok, res_err, vec_val(res_vec), e.prod);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit ok;
        issue(8'b01_00_01_00, 8'b11_00_01_00, -1, 1'b0, 1'b1);
        e = exp_q.pop_back();
        for (int i = 0; i < 3; i++) @(negedge clk);  // RUN step k=2
        tests_run++;
        if (mul_x !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_mid_pre_mul_x: got %b, want 01", mul_x);
        end
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({start_ready, res_valid, res_err, mul_clear, mul_x, mul_y} !== 8'b1000_0000 ||
            res_vec !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got ctrl=%b vec=%h, want ctrl=10000000 vec=00",
                     {start_ready, res_valid, res_err, mul_clear, mul_x, mul_y}, res_vec);
        end
        #1 reset_n = 1'b1;
        @(negedge clk);
        issue(8'b01_01_00_00, 8'b01_01_00_00, -1, 1'b0, 1'b1);
        tests_run++;
        if (mul_clear !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh_clear: got %b, want 1", mul_clear);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || abs_i(vec_val(res_vec) * 16 - e.prod) > 16 || res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_next_op: got ok=%0d %0d/16 err=%b, want ok=1 %0d/256 +-16/256 err=0",
                     ok, vec_val(res_vec), res_err, e.prod);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_abort();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
